// File: rtl/gap_state_detect.sv
// Box-car averages gap/current mV samples and classifies OPEN/DISCHARGE/SHORT; GAP_DEBOUNCE_EN enables state debounce.
// Latency: averages 1 cycle after the last window sample, gap_state/short_alarm one cycle after that.
// Backpressure: none, one sample accepted per cycle while i_det_en is high; deasserting discards the partial window.
module gap_state_detect #(
    parameter int AVG_SHIFT   = 4,
    parameter int OPEN_TH_MV  = 2500,
    parameter int SHORT_TH_MV = 500,
    parameter int CURR_TH_MV  = 300,
    parameter int DEBOUNCE    = 3,
    parameter int ALARM_WIN   = 8
) (
    input  logic        ad_clk,
    input  logic        sys_rst_n,
    input  logic        i_det_en,
    input  logic [11:0] i_volt_mv,
    input  logic [11:0] i_curr_mv,
    output logic [11:0] o_avg_volt,
    output logic [11:0] o_avg_curr,
    output logic        o_avg_valid,
    output logic [1:0]  o_gap_state,
    output logic        o_state_valid,
    output logic        o_short_alarm
);

    localparam int          ACC_W    = 12 + AVG_SHIFT;
    localparam logic [11:0] OPEN_TH  = 12'(OPEN_TH_MV);
    localparam logic [11:0] SHORT_TH = 12'(SHORT_TH_MV);
    localparam logic [11:0] CURR_TH  = 12'(CURR_TH_MV);
    localparam logic [7:0]  ALARM_TH = 8'(ALARM_WIN);

    typedef enum logic [1:0] {
        ST_OPEN  = 2'b00,
        ST_DISCH = 2'b01,
        ST_SHORT = 2'b10
    } state_t;

    if (AVG_SHIFT < 1 || AVG_SHIFT > 8) begin : g_bad_shift
        $error("gap_state_detect: AVG_SHIFT must be 1..8");
    end
    if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_debounce
        $error("gap_state_detect: DEBOUNCE must be 1..15");
    end
    if (ALARM_WIN < 1 || ALARM_WIN > 255) begin : g_bad_alarm
        $error("gap_state_detect: ALARM_WIN must be 1..255");
    end

    logic [ACC_W-1:0]     r_acc_volt;
    logic [ACC_W-1:0]     r_acc_curr;
    logic [AVG_SHIFT-1:0] r_smp_cnt;
    logic [11:0]          r_avg_volt;
    logic [11:0]          r_avg_curr;
    logic                 r_avg_valid;
    logic                 r_state_valid;
    logic [7:0]           r_run;
    state_t               r_state;

    logic [ACC_W-1:0]     w_sum_volt;
    logic [ACC_W-1:0]     w_sum_curr;
    logic                 w_last;
    state_t               w_raw;
    logic                 w_raw_indet;
    state_t               w_state_nxt;

    // Sum of a full window of 12-bit samples always fits in ACC_W bits.
    assign w_sum_volt = r_acc_volt + ACC_W'(i_volt_mv);
    assign w_sum_curr = r_acc_curr + ACC_W'(i_curr_mv);
    assign w_last     = (r_smp_cnt == '1);

    always_ff @(posedge ad_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_acc_volt  <= '0;
            r_acc_curr  <= '0;
            r_smp_cnt   <= '0;
            r_avg_volt  <= '0;
            r_avg_curr  <= '0;
            r_avg_valid <= 1'b0;
        end else if (!i_det_en) begin
            r_acc_volt  <= '0;
            r_acc_curr  <= '0;
            r_smp_cnt   <= '0;
            r_avg_valid <= 1'b0;
        end else if (w_last) begin
            r_avg_volt  <= w_sum_volt[ACC_W-1:AVG_SHIFT];
            r_avg_curr  <= w_sum_curr[ACC_W-1:AVG_SHIFT];
            r_acc_volt  <= '0;
            r_acc_curr  <= '0;
            r_smp_cnt   <= '0;
            r_avg_valid <= 1'b1;
        end else begin
            r_acc_volt  <= w_sum_volt;
            r_acc_curr  <= w_sum_curr;
            r_smp_cnt   <= r_smp_cnt + 1'b1;
            r_avg_valid <= 1'b0;
        end
    end

    // Raw classification; order matters where the regions overlap.
    always_comb begin
        w_raw       = ST_OPEN;
        w_raw_indet = 1'b0;
        if (r_avg_curr < CURR_TH && r_avg_volt >= OPEN_TH) begin
            w_raw = ST_OPEN;
        end else if (r_avg_curr >= CURR_TH && r_avg_volt < SHORT_TH) begin
            w_raw = ST_SHORT;
        end else if (r_avg_curr >= CURR_TH) begin
            w_raw = ST_DISCH;
        end else begin
            w_raw_indet = 1'b1;
        end
    end

`ifdef GAP_DEBOUNCE_EN
    localparam logic [3:0] DB_TH = 4'(DEBOUNCE);

    state_t     r_cand;
    logic [3:0] r_db_cnt;
    state_t     w_cand_nxt;
    logic [3:0] w_db_cnt_nxt;
    logic [3:0] w_db_inc;

    always_comb begin
        w_state_nxt  = r_state;
        w_cand_nxt   = r_cand;
        w_db_cnt_nxt = r_db_cnt;
        w_db_inc     = 4'd0;
        if (r_avg_valid) begin
            if (w_raw_indet || w_raw == r_state) begin
                w_db_cnt_nxt = 4'd0;
            end else begin
                if (w_raw != r_cand) begin
                    w_cand_nxt = w_raw;
                    w_db_inc   = 4'd1;
                end else begin
                    w_db_inc   = r_db_cnt + 4'd1;
                end
                if (w_db_inc == DB_TH) begin
                    w_state_nxt  = w_cand_nxt;
                    w_db_cnt_nxt = 4'd0;
                end else begin
                    w_db_cnt_nxt = w_db_inc;
                end
            end
        end
        // A pending evaluation still lands in gap_state, but the debounce history is dropped.
        if (!i_det_en) begin
            w_cand_nxt   = ST_OPEN;
            w_db_cnt_nxt = 4'd0;
        end
    end

    always_ff @(posedge ad_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cand   <= ST_OPEN;
            r_db_cnt <= 4'd0;
        end else begin
            r_cand   <= w_cand_nxt;
            r_db_cnt <= w_db_cnt_nxt;
        end
    end
`else
    always_comb begin
        w_state_nxt = r_state;
        if (r_avg_valid && !w_raw_indet) begin
            w_state_nxt = w_raw;
        end
    end
`endif

    always_ff @(posedge ad_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_OPEN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge ad_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state_valid <= 1'b0;
            r_run         <= 8'd0;
        end else begin
            r_state_valid <= r_avg_valid;
            if (r_avg_valid) begin
                if (w_state_nxt != ST_SHORT) begin
                    r_run <= 8'd0;
                end else if (r_run != 8'hFF) begin
                    r_run <= r_run + 8'd1;
                end
            end
        end
    end

    always_comb begin
        o_gap_state   = r_state;
        o_state_valid = r_state_valid;
        o_short_alarm = (r_run >= ALARM_TH);
    end

    assign o_avg_volt  = r_avg_volt;
    assign o_avg_curr  = r_avg_curr;
    assign o_avg_valid = r_avg_valid;

endmodule
